memacc: RTL and testbench

MEMACC -- requirements
Module: memacc

---
 rtl/memacc.sv | 147 ++++++++++++++
 tb/tb_memacc.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/memacc.sv
// Memory-access stage: issues one data-bus transaction per load/store,
// stalls the pipeline while it is outstanding, and lane-aligns load/store data.
module memacc (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_stall,
  input  logic        reg_flush,
  output logic        mem_stall,
  input  logic [3:0]  mem_op,
  input  logic [31:0] result,
  input  logic [31:0] source_data,
  output logic        dbus_req,
  output logic        dbus_wr,
  output logic [1:0]  dbus_size,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_addr_ok,
  input  logic        dbus_data_ok,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] load_data,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_vaddr
);
  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic [3:0]  op_q, op_d;

  logic        is_load, is_store, is_half, is_word, misalign, launch;
  logic [1:0]  size_new;
  logic [31:0] wdata_new, byte_lane;
  logic [15:0] half_lane;

  assign is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
  assign is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
  assign is_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
  assign is_word  = (mem_op == OP_LW) || (mem_op == OP_SW);
  assign misalign = (is_half && result[0]) || (is_word && (result[1:0] != 2'b00));

  assign adel      = is_load && misalign;
  assign ades      = is_store && misalign;
  assign bad_vaddr = (adel || ades) ? result : 32'h0;

  assign launch = (state_q == S_IDLE) && (is_load || is_store) && !misalign &&
                  !reg_flush && !rst;

  always_comb begin
    size_new  = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
    wdata_new = source_data;
    if (mem_op == OP_SB)      wdata_new = {4{source_data[7:0]}};
    else if (mem_op == OP_SH) wdata_new = {2{source_data[15:0]}};
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: if (launch) begin
        state_d = S_REQ;
        addr_d  = result;
        size_d  = size_new;
        wr_d    = is_store;
        wdata_d = wdata_new;
        op_d    = mem_op;
      end
      S_REQ: begin
        if (dbus_addr_ok) begin
          if (dbus_data_ok) rdata_d = dbus_rdata;
          // Once the address is accepted a response is owed, so a flush must drain it.
          if (reg_flush) state_d = dbus_data_ok ? S_IDLE : S_DRAIN;
          else           state_d = dbus_data_ok ? S_DONE : S_WAIT;
        end else if (reg_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dbus_data_ok) begin
          rdata_d = dbus_rdata;
          state_d = reg_flush ? S_IDLE : S_DONE;
        end else if (reg_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  if (reg_flush || !reg_stall) state_d = S_IDLE;
      S_DRAIN: if (dbus_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      op_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
    end
  end

  assign dbus_req   = (state_q == S_REQ);
  assign dbus_wr    = wr_q;
  assign dbus_size  = size_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = wdata_q;
  assign mem_stall  = launch || (state_q == S_REQ) || (state_q == S_WAIT) ||
                      (state_q == S_DRAIN);

  // Little-endian lanes: byte n of the word lives in bits [8n+7:8n].
  assign byte_lane = rdata_q >> {addr_q[1:0], 3'b000};
  assign half_lane = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_data = '0;
    if (state_q == S_DONE) begin
      case (op_q)
        OP_LB:   load_data = {{24{byte_lane[7]}}, byte_lane[7:0]};
        OP_LBU:  load_data = {24'h0, byte_lane[7:0]};
        OP_LH:   load_data = {{16{half_lane[15]}}, half_lane};
        OP_LHU:  load_data = {16'h0, half_lane};
        OP_LW:   load_data = rdata_q;
        default: load_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_memacc.sv
// Directed bench for memacc: inputs change 1ns after the rising edge,
// outputs are checked on the falling edge.
module tb_memacc;
  logic        clk = 1'b0;
  logic        rst, reg_stall, reg_flush, mem_stall;
  logic [3:0]  mem_op;
  logic [31:0] result, source_data;
  logic        dbus_req, dbus_wr;
  logic [1:0]  dbus_size;
  logic [31:0] dbus_addr, dbus_wdata;
  logic        dbus_addr_ok, dbus_data_ok;
  logic [31:0] dbus_rdata, load_data;
  logic        adel, ades;
  logic [31:0] bad_vaddr;

  int n_vec = 0, n_err = 0, hs_cnt = 0, hs_base;

  memacc dut (
    .clk(clk), .rst(rst), .reg_stall(reg_stall), .reg_flush(reg_flush),
    .mem_stall(mem_stall), .mem_op(mem_op), .result(result),
    .source_data(source_data), .dbus_req(dbus_req), .dbus_wr(dbus_wr),
    .dbus_size(dbus_size), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_addr_ok(dbus_addr_ok), .dbus_data_ok(dbus_data_ok),
    .dbus_rdata(dbus_rdata), .load_data(load_data), .adel(adel), .ades(ades),
    .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && dbus_req && dbus_addr_ok) hs_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; reg_stall = 0; reg_flush = 0; mem_op = 0; result = 0; source_data = 0;
    dbus_addr_ok = 0; dbus_data_ok = 0; dbus_rdata = 0;
    nxt(); nxt();
    mid();
    chk("rst_req", dbus_req, 0);     chk("rst_stall", mem_stall, 0);
    chk("rst_addr", dbus_addr, 0);   chk("rst_load", load_data, 0);
    nxt(); rst = 0;

    // LB at 0x1003, addr_ok then data_ok one cycle later
    mem_op = 1; result = 32'h1003;
    mid(); chk("lb_launch_stall", mem_stall, 1); chk("lb_launch_req", dbus_req, 0);
    chk("lb_adel", adel, 0);
    nxt(); dbus_addr_ok = 1;
    mid(); chk("lb_req", dbus_req, 1); chk("lb_addr", dbus_addr, 32'h1003);
    chk("lb_size", dbus_size, 0); chk("lb_wr", dbus_wr, 0); chk("lb_req_stall", mem_stall, 1);
    nxt(); dbus_addr_ok = 0; dbus_data_ok = 1; dbus_rdata = 32'h80FF_1234;
    mid(); chk("lb_wait_req", dbus_req, 0); chk("lb_wait_stall", mem_stall, 1);
    nxt(); dbus_data_ok = 0; dbus_rdata = 32'h5555_5555; mem_op = 0;
    mid(); chk("lb_done_stall", mem_stall, 0); chk("lb_load", load_data, 32'hFFFF_FF80);
    nxt();
    mid(); chk("lb_idle_load", load_data, 0);

    // SH of 0xABCD at 0x2002, addr_ok and data_ok together
    nxt(); mem_op = 7; result = 32'h2002; source_data = 32'h0000_ABCD;
    mid(); chk("sh_launch_stall", mem_stall, 1); chk("sh_ades", ades, 0);
    nxt(); dbus_addr_ok = 1; dbus_data_ok = 1; dbus_rdata = 32'hFFFF_FFFF;
    mid(); chk("sh_req", dbus_req, 1); chk("sh_wr", dbus_wr, 1);
    chk("sh_wdata", dbus_wdata, 32'hABCD_ABCD); chk("sh_size", dbus_size, 1);
    chk("sh_addr", dbus_addr, 32'h2002);
    nxt(); dbus_addr_ok = 0; dbus_data_ok = 0; mem_op = 0;
    mid(); chk("sh_done_stall", mem_stall, 0); chk("sh_done_req", dbus_req, 0);
    chk("sh_load", load_data, 0);

    // misaligned LW / SW, plus aligned bad_vaddr
    nxt(); mem_op = 5; result = 32'h1002;
    mid(); chk("lw_adel", adel, 1); chk("lw_ades", ades, 0);
    chk("lw_badva", bad_vaddr, 32'h1002); chk("lw_stall", mem_stall, 0);
    nxt();
    mid(); chk("lw_noreq", dbus_req, 0); chk("lw_stall2", mem_stall, 0);
    nxt(); mem_op = 8; result = 32'h3001;
    mid(); chk("sw_ades", ades, 1); chk("sw_adel", adel, 0); chk("sw_badva", bad_vaddr, 32'h3001);
    nxt(); mem_op = 3; result = 32'h3002; reg_flush = 1;
    mid(); chk("lh_ok_badva", bad_vaddr, 0); chk("lh_flush_stall", mem_stall, 0);
    nxt(); mem_op = 0; reg_flush = 0;
    mid(); chk("mis_noreq", dbus_req, 0);

    // flush in WAIT -> DRAIN, late data_ok discarded
    nxt(); mem_op = 5; result = 32'h4000;
    nxt(); dbus_addr_ok = 1;
    nxt(); dbus_addr_ok = 0; reg_flush = 1;
    mid(); chk("fl_wait_stall", mem_stall, 1);
    nxt(); reg_flush = 0; mem_op = 0;
    mid(); chk("fl_drain_stall", mem_stall, 1); chk("fl_drain_req", dbus_req, 0);
    nxt(); dbus_data_ok = 1; dbus_rdata = 32'hDEAD_BEEF;
    mid(); chk("fl_drain_stall2", mem_stall, 1);
    nxt(); dbus_data_ok = 0;
    mid(); chk("fl_idle_stall", mem_stall, 0); chk("fl_load", load_data, 0);
    chk("fl_req", dbus_req, 0);

    // LHU at 0x10 held in DONE by reg_stall for 3 cycles
    hs_base = hs_cnt;
    nxt(); mem_op = 4; result = 32'h10; reg_stall = 1;
    nxt(); dbus_addr_ok = 1;
    nxt(); dbus_addr_ok = 0; dbus_data_ok = 1; dbus_rdata = 32'h1234_8765;
    nxt(); dbus_data_ok = 0; dbus_rdata = 0;
    for (int i = 0; i < 3; i++) begin
      mid(); chk($sformatf("lhu_hold%0d_load", i), load_data, 32'h0000_8765);
      chk($sformatf("lhu_hold%0d_stall", i), mem_stall, 0);
      chk($sformatf("lhu_hold%0d_req", i), dbus_req, 0);
      if (i < 2) nxt();
    end
    nxt(); reg_stall = 0; mem_op = 0;
    mid(); chk("lhu_rel_load", load_data, 32'h0000_8765);
    nxt();
    mid(); chk("lhu_idle_load", load_data, 0);
    chk("lhu_handshakes", hs_cnt - hs_base, 1);

    // LH at 0x12, upper half sign-extended
    nxt(); mem_op = 3; result = 32'h12;
    nxt(); dbus_addr_ok = 1; dbus_data_ok = 1; dbus_rdata = 32'h8001_0000;
    nxt(); dbus_addr_ok = 0; dbus_data_ok = 0; mem_op = 0;
    mid(); chk("lh_load", load_data, 32'hFFFF_8001);

    // reset in REQ with flush/stall also asserted
    nxt(); mem_op = 8; result = 32'h5000; source_data = 32'h1122_3344;
    nxt();
    mid(); chk("rs_req", dbus_req, 1); chk("rs_wdata", dbus_wdata, 32'h1122_3344);
    rst = 1; reg_flush = 1; reg_stall = 1;
    nxt(); rst = 0; reg_flush = 0; reg_stall = 0; mem_op = 0;
    mid(); chk("rs_req0", dbus_req, 0); chk("rs_wr0", dbus_wr, 0);
    chk("rs_size0", dbus_size, 0); chk("rs_addr0", dbus_addr, 0);
    chk("rs_wdata0", dbus_wdata, 0); chk("rs_load0", load_data, 0);
    chk("rs_stall0", mem_stall, 0);
    nxt();
    mid(); chk("rs_still_idle", dbus_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
